// File: rtl/seg_serial_driver.sv
// Serial front end for the shift-register 7-segment display: snapshots a 32-bit value
// plus dp/blank masks, encodes eight active-low digits and shifts the 64-bit frame out.
module seg_serial_driver #(
  parameter int DIV = 4,
  parameter int GAP = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] data,
  input  logic [7:0]  point,
  input  logic [7:0]  les,
  output logic        seg_clk,
  output logic        seg_do,
  output logic        seg_pen,
  output logic        seg_clr,
  output logic        busy,
  output logic        frame_done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      shreg_q, shreg_d;
  logic [5:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             sclk_q, sclk_d;
  logic             clr_q;
  logic             half_end;
  logic             bit_end;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  // Blanking wins over the decimal point so a blanked digit stays fully dark.
  function automatic logic [7:0] digit_code(input logic [3:0] nib, input logic dp,
                                            input logic blank);
    logic [7:0] code;
    code = hex_to_seg(nib);
    if (dp)
      code[7] = 1'b0;
    if (blank)
      code = 8'hFF;
    return code;
  endfunction

  function automatic logic [63:0] build_frame(input logic [31:0] d, input logic [7:0] p,
                                              input logic [7:0] l);
    logic [63:0] frame;
    frame = '0;
    for (int i = 0; i < 8; i++)
      frame[8*i +: 8] = digit_code(d[4*i +: 4], p[i], l[i]);
    return frame;
  endfunction

  assign half_end = (div_q == DIV_LAST);
  assign bit_end  = half_end && sclk_q && (bit_q == 6'd0);

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (bit_end) state_d = S_LATCH;
      S_LATCH: state_d = (GAP == 0) ? S_LOAD : S_GAP;
      S_GAP:   if (gap_q == GAP_LAST) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, shift clock and shift register; data shifts on the falling seg_clk toggle
  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    case (state_q)
      S_LOAD: begin
        shreg_d = build_frame(data, point, les);
        bit_d   = 6'd63;
        div_d   = '0;
        sclk_d  = 1'b0;
      end
      S_SHIFT: begin
        if (half_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            shreg_d = {shreg_q[62:0], 1'b0};
            bit_d   = bit_q - 6'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: gap_d = '0;
      S_GAP:   gap_d = gap_q + GAP_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      bit_q  <= '0;
      div_q  <= '0;
      gap_q  <= '0;
      sclk_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      bit_q  <= bit_d;
      div_q  <= div_d;
      gap_q  <= gap_d;
      sclk_q <= sclk_d;
      clr_q  <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    shreg_q <= shreg_d;
  end

  // Output decode; seg_do is gated so it is 0 outside SHIFT and during reset
  always_comb begin
    seg_clk    = sclk_q;
    seg_do     = 1'b0;
    seg_pen    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_LOAD:  busy = 1'b1;
      S_SHIFT: begin
        seg_do = shreg_q[63];
        busy   = 1'b1;
      end
      S_LATCH: begin
        seg_pen    = 1'b1;
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      S_GAP:   seg_pen = 1'b1;
      default: ;
    endcase
  end

  assign seg_clr = clr_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: two instances (DIV=2/GAP=4 and DIV=1/GAP=0) observed by a
// display-side shift-register model and compared against frames computed from the inputs.
module tb_seg_serial_driver;

  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [31:0] data0, data1;
  logic [7:0]  point0, point1, les0, les1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        done1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame: digit 7 first, each byte looked up then dp-cleared then blank-forced.
  function automatic logic [63:0] model_frame(input logic [31:0] d, input logic [7:0] p,
                                              input logic [7:0] l);
    logic [7:0]  b;
    logic [63:0] f;
    f = '0;
    for (int i = 7; i >= 0; i--) begin
      b = HEX[d[4*i +: 4]];
      if (p[i]) b = b & 8'h7F;
      if (l[i]) b = 8'hFF;
      f = {f[55:0], b};
    end
    return f;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DV = (g == 0) ? 2 : 1;
    localparam int GP = (g == 0) ? 4 : 0;

    logic        rin;
    logic [31:0] din;
    logic [7:0]  pin, lin;
    logic        seg_clk, seg_do, seg_pen, seg_clr, busy, frame_done;

    assign rin = (g == 0) ? rst0 : rst1;
    assign din = (g == 0) ? data0 : data1;
    assign pin = (g == 0) ? point0 : point1;
    assign lin = (g == 0) ? les0 : les1;

    seg_serial_driver #(.DIV(DV), .GAP(GP)) u_dut (
      .CLK        (clk),
      .Reset      (rin),
      .data       (din),
      .point      (pin),
      .les        (lin),
      .seg_clk    (seg_clk),
      .seg_do     (seg_do),
      .seg_pen    (seg_pen),
      .seg_clr    (seg_clr),
      .busy       (busy),
      .frame_done (frame_done)
    );

    int          rises = 0;
    int          nframes = 0;
    int          last_load = -1;
    int          viol = 0;
    int          pen_rises = 0;
    logic [63:0] cap = '0;
    logic [63:0] last_frame = '0;
    logic        prev_clk = 1'b0, prev_do = 1'b0, prev_pen = 1'b0, prev_busy = 1'b0;
    logic        load = 1'b0, prev_load = 1'b0;
    logic [63:0] expq [$];

    always @(negedge clk) begin
      if (!rin) begin
        rises = 0;
        cap = '0;
        viol = 0;
        last_load = -1;
        load = 1'b0;
        expq.delete();
      end else begin
        load = (busy && !prev_busy) || (!seg_pen && prev_pen);
        if (load) begin
          expq.push_back(model_frame(din, pin, lin));
          if (last_load >= 0)
            chk($sformatf("period%0d", g), cyc - last_load, 2 + 128 * DV + GP);
          last_load = cyc;
        end
        if (seg_clk && seg_do !== prev_do) viol++;
        if (DV == 1 && busy && !seg_pen && !load && !prev_load && seg_clk == prev_clk) viol++;
        if (seg_clk && !prev_clk) begin
          rises++;
          cap = {cap[62:0], seg_do};
        end
        if (frame_done) begin
          chk($sformatf("rises%0d", g), rises, 64);
          chk($sformatf("clk_at_latch%0d", g), seg_clk, 0);
          chk($sformatf("pen_at_latch%0d", g), seg_pen, 1);
          chk($sformatf("busy_at_latch%0d", g), busy, 1);
          chk($sformatf("shift_len%0d", g), cyc - last_load, 1 + 128 * DV);
          chk($sformatf("do_stable%0d", g), viol, 0);
          chk($sformatf("expq%0d", g), expq.size() > 0, 1);
          if (expq.size() > 0)
            chk($sformatf("frame%0d", g), cap, expq.pop_front());
          last_frame = cap;
          nframes++;
          rises = 0;
          viol = 0;
        end
      end
      if (seg_pen && !prev_pen) pen_rises++;
      prev_clk  = seg_clk;
      prev_do   = seg_do;
      prev_pen  = seg_pen;
      prev_busy = busy;
      prev_load = load;
    end
  end

  task automatic wait_frames(input int n);
    int start = g_dut[0].nframes;
    int t = 0;
    while (g_dut[0].nframes < start + n && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("wait_frames", g_dut[0].nframes >= start + n, 1);
  endtask

  task automatic wait_rises(input int n);
    int t = 0;
    while (g_dut[0].rises != n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("wait_rises", g_dut[0].rises, n);
  endtask

  initial begin
    int pr;
    int t;
    rst0 = 1'b0;
    data0 = 32'h0123_4567;
    point0 = 8'h00;
    les0 = 8'h00;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_outs0", {g_dut[0].seg_clk, g_dut[0].seg_do, g_dut[0].seg_pen,
                      g_dut[0].seg_clr, g_dut[0].busy, g_dut[0].frame_done}, 0);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_after_rst", g_dut[0].seg_clr, 1);
    chk("busy_in_load", g_dut[0].busy, 1);
    chk("pen_in_load", g_dut[0].seg_pen, 0);

    wait_frames(2);
    chk("frame_0123", g_dut[0].last_frame, 64'hC0F9A4B0_999282F8);

    data0 = 32'h89AB_CDEF;
    wait_frames(2);
    chk("frame_89AB", g_dut[0].last_frame, 64'h80908883_C6A1868E);

    data0 = 32'h0;
    point0 = 8'h80;
    les0 = 8'h01;
    wait_frames(2);
    chk("frame_dp_blank", g_dut[0].last_frame, 64'h40C0C0C0_C0C0C0FF);

    point0 = 8'h81;
    les0 = 8'h81;
    wait_frames(2);
    chk("frame_blank_wins", g_dut[0].last_frame, 64'hFFC0C0C0_C0C0C0FF);

    data0 = 32'h1111_1111;
    point0 = 8'h00;
    les0 = 8'h00;
    wait_frames(2);
    wait_rises(33);
    data0 = 32'h2222_2222;
    wait_frames(1);
    chk("frame_inflight", g_dut[0].last_frame, {8{8'hF9}});
    wait_frames(1);
    chk("frame_next", g_dut[0].last_frame, {8{8'hA4}});

    wait_rises(24);
    pr = g_dut[0].pen_rises;
    rst0 = 1'b0;
    #1;
    chk("midreset_outs", {g_dut[0].seg_clk, g_dut[0].seg_do, g_dut[0].seg_pen,
                          g_dut[0].seg_clr, g_dut[0].busy, g_dut[0].frame_done}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_pen_on_reset", g_dut[0].pen_rises, pr);
    rst0 = 1'b1;
    wait_frames(1);
    chk("frame_after_reset", g_dut[0].last_frame, {8{8'hA4}});

    for (int k = 0; k < 16; k++) begin
      data0 = $urandom;
      point0 = 8'($urandom_range(0, 255));
      les0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      repeat ($urandom_range(1, 600)) @(posedge clk);
      #1;
    end
    wait_frames(2);

    t = 0;
    while (!done1 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("inst1_done", done1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst1 = 1'b0;
    data1 = 32'h0;
    point1 = 8'h00;
    les1 = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_outs1", {g_dut[1].seg_clk, g_dut[1].seg_do, g_dut[1].seg_pen,
                      g_dut[1].seg_clr, g_dut[1].busy, g_dut[1].frame_done}, 0);
    rst1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data1 = $urandom;
      point1 = 8'($urandom_range(0, 255));
      les1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      repeat ($urandom_range(1, 300)) @(posedge clk);
      #1;
    end
    repeat (300) @(posedge clk);
    #1;
    chk("frames1", g_dut[1].nframes > 10, 1);
    done1 = 1'b1;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog cycles=%0d limit=90000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
